sync_fifo: RTL and testbench

Single-clock, parametrised FIFO that wraps a dual-port storage array with a configurable read pipeline and a valid/ready interface on both sides. It generalises the plain storage RAM into a complete buffering block: it owns the pointers, occupancy count, almost-full/almost-empty flags and synchronous flush. An output skid buffer hides read-pipeline latency, so sustained throughput is one word per cycle for any pipeline depth. It is used wherever a stream crosses between sub-blocks inside one clock domain.

---
 rtl/sync_fifo.sv | 232 +++++++++++++++++++++++
 tb/tb_sync_fifo.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with configurable read pipeline and output skid buffer
module sync_fifo #(
  parameter int    DATA_WIDTH = 32,
  parameter int    DEPTH      = 16,
  parameter int    ADDR_WIDTH = 4,
  parameter int    OUTPUT_REG = 1,
  parameter int    AF_TH      = DEPTH - 2,
  parameter int    AE_TH      = 1,
  parameter string RAM_TYPE   = "block"
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  almost_full,
  output logic                  almost_empty
);

  localparam int CW = ADDR_WIDTH + 1;
  localparam int L  = OUTPUT_REG;

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_TH);
  localparam logic [CW-1:0] AE_C    = CW'(AE_TH);

  // ---------------------------------------------------------------------------
  // Elaboration-time parameter checks
  // ---------------------------------------------------------------------------
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_chk_depth
    $error("sync_fifo: DEPTH must be a power of two and at least 2");
  end

  if (ADDR_WIDTH != $clog2(DEPTH)) begin : g_chk_addr
    $error("sync_fifo: ADDR_WIDTH must equal log2(DEPTH)");
  end

  if (OUTPUT_REG < 0 || OUTPUT_REG > 3) begin : g_chk_lat
    $error("sync_fifo: OUTPUT_REG must be in 0..3");
  end

  if (AF_TH < 1 || AF_TH > DEPTH) begin : g_chk_af
    $error("sync_fifo: AF_TH must be in 1..DEPTH");
  end

  if (AE_TH < 0 || AE_TH > DEPTH - 1) begin : g_chk_ae
    $error("sync_fifo: AE_TH must be in 0..DEPTH-1");
  end

  if (RAM_TYPE != "block" && RAM_TYPE != "distributed" &&
      RAM_TYPE != "register" && RAM_TYPE != "ultra") begin : g_chk_ram
    $error("sync_fifo: RAM_TYPE must be block, distributed, register or ultra");
  end

  // A block RAM cannot provide the combinational read that show-ahead needs.
  if (RAM_TYPE == "block" && OUTPUT_REG == 0) begin : g_warn_ram
    $warning("sync_fifo: block RAM with OUTPUT_REG=0 is built as distributed");
  end

  // ---------------------------------------------------------------------------
  // Storage, pointers and occupancy
  // ---------------------------------------------------------------------------
  (* ram_style = (RAM_TYPE == "block" && OUTPUT_REG == 0) ? "distributed" : RAM_TYPE *)
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q,  count_d;

  logic wr_acc;   // word accepted from the producer this cycle
  logic rd_acc;   // head word taken by the consumer this cycle
  logic rd_adv;   // rd_ptr moves on (pop in show-ahead, issue otherwise)

  // wr_ready looks only at registered state so it never depends on wr_valid.
  assign wr_ready     = (count_q != DEPTH_C);
  assign wr_acc       = wr_valid & wr_ready & ~flush & rst_n;
  assign rd_acc       = rd_valid & rd_ready & ~flush;

  assign count        = count_q;
  assign almost_full  = (count_q >= AF_C);
  assign almost_empty = (count_q <= AE_C);

  // Write port; contents survive reset and flush.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr_q] <= wr_data;
    end
  end

  // Next pointer and occupancy; flush wins over any same-cycle write or pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_acc) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (rd_adv) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({wr_acc, rd_acc})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Read side
  // ---------------------------------------------------------------------------
  if (L == 0) begin : g_show_ahead

    assign rd_valid = (count_q != '0);
    assign rd_data  = mem[rd_ptr_q];
    assign rd_adv   = rd_acc;

  end else begin : g_pipe

    logic [L-1:0]          pipe_vld_q, pipe_vld_d;
    logic [DATA_WIDTH-1:0] pipe_data_q [L];
    logic [DATA_WIDTH-1:0] pipe_data_d [L];

    // Skid holds L+1 words so every word already in flight has a slot when
    // the consumer stalls. Entry 0 is the head.
    logic [DATA_WIDTH-1:0] skid_data_q [L+1];
    logic [DATA_WIDTH-1:0] skid_data_d [L+1];
    logic [2:0]            skid_cnt_q, skid_cnt_d;
    logic [2:0]            skid_left;

    logic [2:0]    infl;       // words travelling through the read pipeline
    logic [3:0]    pend;       // in-flight plus skid, after this cycle's pop
    logic [CW-1:0] unissued;   // words still only in the RAM
    logic          issue;

    // Count the valid pipeline stages.
    always_comb begin
      infl = '0;
      for (int k = 0; k < L; k++) begin
        infl = infl + 3'(pipe_vld_q[k]);
      end
    end

    assign unissued = count_q - CW'(infl) - CW'(skid_cnt_q);
    assign pend     = {1'b0, infl} + {1'b0, skid_cnt_q} - 4'(rd_acc);
    assign issue    = (unissued != '0) && (pend < 4'(L + 1));
    assign rd_adv   = issue;

    assign rd_valid = (skid_cnt_q != '0);
    assign rd_data  = skid_data_q[0];

    // Advance the read pipeline and refill the skid buffer behind the head.
    always_comb begin
      pipe_vld_d  = pipe_vld_q;
      pipe_data_d = pipe_data_q;
      skid_data_d = skid_data_q;
      skid_left   = skid_cnt_q - 3'(rd_acc);

      pipe_vld_d[0] = issue;
      if (issue) begin
        pipe_data_d[0] = mem[rd_ptr_q];
      end
      for (int k = 1; k < L; k++) begin
        pipe_vld_d[k]  = pipe_vld_q[k-1];
        pipe_data_d[k] = pipe_data_q[k-1];
      end

      if (rd_acc) begin
        for (int i = 0; i < L; i++) begin
          skid_data_d[i] = skid_data_q[i+1];
        end
      end
      if (pipe_vld_q[L-1]) begin
        for (int i = 0; i <= L; i++) begin
          if (skid_left == 3'(i)) begin
            skid_data_d[i] = pipe_data_q[L-1];
          end
        end
      end
      skid_cnt_d = skid_left + 3'(pipe_vld_q[L-1]);

      if (flush) begin
        pipe_vld_d = '0;
        skid_cnt_d = '0;
      end
    end

    // Pipeline and skid registers.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        pipe_vld_q <= '0;
        skid_cnt_q <= '0;
        for (int k = 0; k < L; k++) begin
          pipe_data_q[k] <= '0;
        end
        for (int i = 0; i <= L; i++) begin
          skid_data_q[i] <= '0;
        end
      end else begin
        pipe_vld_q  <= pipe_vld_d;
        pipe_data_q <= pipe_data_d;
        skid_cnt_q  <= skid_cnt_d;
        skid_data_q <= skid_data_d;
      end
    end

  end

endmodule

// File: tb/tb_sync_fifo.sv
// tb/tb_sync_fifo.sv - directed self-checking bench for sync_fifo at read latencies 0..3
module tb_sync_fifo;

  localparam int NI = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush        [NI];
  logic        wr_valid     [NI];
  logic        wr_ready     [NI];
  logic [31:0] wr_data      [NI];
  logic        rd_valid     [NI];
  logic        rd_ready     [NI];
  logic [31:0] rd_data      [NI];
  logic [4:0]  count        [NI];
  logic        almost_full  [NI];
  logic        almost_empty [NI];

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  // Instance g has a read pipeline of g stages.
  for (genvar g = 0; g < NI; g++) begin : g_dut
    sync_fifo #(
      .DATA_WIDTH(32),
      .DEPTH(16),
      .ADDR_WIDTH(4),
      .OUTPUT_REG(g),
      .AF_TH(14),
      .AE_TH(1),
      .RAM_TYPE(g == 0 ? "distributed" : "block")
    ) u_dut (
      .clk(clk),
      .rst_n(rst_n),
      .flush(flush[g]),
      .wr_valid(wr_valid[g]),
      .wr_ready(wr_ready[g]),
      .wr_data(wr_data[g]),
      .rd_valid(rd_valid[g]),
      .rd_ready(rd_ready[g]),
      .rd_data(rd_data[g]),
      .count(count[g]),
      .almost_full(almost_full[g]),
      .almost_empty(almost_empty[g])
    );
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < NI; i++) begin
      flush[i] = 1'b0; wr_valid[i] = 1'b0; wr_data[i] = '0; rd_ready[i] = 1'b0;
    end
    rst_n = 1'b0;
    repeat (3) cyc();
    n_total++; if (wr_ready[2] !== 1'b1) $display("FAIL rst_wr_ready: got %b want 1", wr_ready[2]); else n_pass++;
    n_total++; if (rd_valid[2] !== 1'b0) $display("FAIL rst_rd_valid: got %b want 0", rd_valid[2]); else n_pass++;
    n_total++; if (rd_data[2] !== 32'h0) $display("FAIL rst_rd_data: got %h want 0", rd_data[2]); else n_pass++;
    n_total++; if (count[2] !== 5'd0) $display("FAIL rst_count: got %0d want 0", count[2]); else n_pass++;
    n_total++; if (almost_full[2] !== 1'b0) $display("FAIL rst_af: got %b want 0", almost_full[2]); else n_pass++;
    n_total++; if (almost_empty[2] !== 1'b1) $display("FAIL rst_ae: got %b want 1", almost_empty[2]); else n_pass++;
    n_total++; if (rd_valid[0] !== 1'b0) $display("FAIL rst_l0_rd_valid: got %b want 0", rd_valid[0]); else n_pass++;
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_latency();
    wr_valid[2] = 1'b1; wr_data[2] = 32'hA5;
    cyc();
    wr_valid[2] = 1'b0;
    n_total++; if (count[2] !== 5'd1) $display("FAIL lat_count: got %0d want 1", count[2]); else n_pass++;
    n_total++; if (rd_valid[2] !== 1'b0) $display("FAIL lat_e0: got %b want 0", rd_valid[2]); else n_pass++;
    cyc();
    n_total++; if (rd_valid[2] !== 1'b0) $display("FAIL lat_e1: got %b want 0", rd_valid[2]); else n_pass++;
    cyc();
    n_total++; if (rd_valid[2] !== 1'b0) $display("FAIL lat_e2: got %b want 0", rd_valid[2]); else n_pass++;
    cyc();
    n_total++; if (rd_valid[2] !== 1'b1) $display("FAIL lat_e3_valid: got %b want 1", rd_valid[2]); else n_pass++;
    n_total++; if (rd_data[2] !== 32'hA5) $display("FAIL lat_e3_data: got %h want a5", rd_data[2]); else n_pass++;
    rd_ready[2] = 1'b1;
    cyc();
    rd_ready[2] = 1'b0;
    n_total++; if (count[2] !== 5'd0) $display("FAIL lat_pop_count: got %0d want 0", count[2]); else n_pass++;
    n_total++; if (rd_valid[2] !== 1'b0) $display("FAIL lat_pop_valid: got %b want 0", rd_valid[2]); else n_pass++;
  endtask

  task automatic test_show_ahead();
    wr_valid[0] = 1'b1; wr_data[0] = 32'h11;
    cyc();
    wr_valid[0] = 1'b0;
    n_total++; if (rd_valid[0] !== 1'b1) $display("FAIL sa_valid: got %b want 1", rd_valid[0]); else n_pass++;
    n_total++; if (rd_data[0] !== 32'h11) $display("FAIL sa_data: got %h want 11", rd_data[0]); else n_pass++;
    n_total++; if (count[0] !== 5'd1) $display("FAIL sa_count: got %0d want 1", count[0]); else n_pass++;
    rd_ready[0] = 1'b1;
    cyc();
    rd_ready[0] = 1'b0;
    n_total++; if (rd_valid[0] !== 1'b0) $display("FAIL sa_pop_valid: got %b want 0", rd_valid[0]); else n_pass++;
  endtask

  task automatic test_fill();
    int exp_w;
    wr_valid[2] = 1'b1;
    for (int i = 0; i < 16; i++) begin
      wr_data[2] = i;
      cyc();
      if (i == 0) begin
        n_total++; if (almost_empty[2] !== 1'b1) $display("FAIL fill_ae_c1: got %b want 1", almost_empty[2]); else n_pass++;
      end
      if (i == 1) begin
        n_total++; if (almost_empty[2] !== 1'b0) $display("FAIL fill_ae_c2: got %b want 0", almost_empty[2]); else n_pass++;
      end
      if (i == 12) begin
        n_total++; if (almost_full[2] !== 1'b0) $display("FAIL fill_af_c13: got %b want 0", almost_full[2]); else n_pass++;
      end
      if (i == 13) begin
        n_total++; if (almost_full[2] !== 1'b1) $display("FAIL fill_af_c14: got %b want 1", almost_full[2]); else n_pass++;
      end
    end
    n_total++; if (count[2] !== 5'd16) $display("FAIL fill_count: got %0d want 16", count[2]); else n_pass++;
    n_total++; if (wr_ready[2] !== 1'b0) $display("FAIL fill_wr_ready: got %b want 0", wr_ready[2]); else n_pass++;
    n_total++; if (almost_full[2] !== 1'b1) $display("FAIL fill_af: got %b want 1", almost_full[2]); else n_pass++;
    wr_data[2] = 32'd99;
    cyc();
    wr_valid[2] = 1'b0;
    n_total++; if (count[2] !== 5'd16) $display("FAIL fill_overrun_count: got %0d want 16", count[2]); else n_pass++;
    exp_w = 0;
    rd_ready[2] = 1'b1;
    for (int c = 0; c < 100 && exp_w < 16; c++) begin
      if (rd_valid[2] === 1'b1) begin
        n_total++; if (rd_data[2] !== 32'(exp_w)) $display("FAIL fill_drain_data: got %0d want %0d", rd_data[2], exp_w); else n_pass++;
        exp_w++;
      end
      cyc();
    end
    rd_ready[2] = 1'b0;
    n_total++; if (exp_w !== 16) $display("FAIL fill_drain_words: got %0d want 16", exp_w); else n_pass++;
    n_total++; if (count[2] !== 5'd0) $display("FAIL fill_drain_count: got %0d want 0", count[2]); else n_pass++;
    cyc();
    n_total++; if (rd_valid[2] !== 1'b0) $display("FAIL fill_no_extra: got %b want 0", rd_valid[2]); else n_pass++;
  endtask

  task automatic test_simul_and_flush();
    int w;
    wr_valid[2] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wr_data[2] = 32'h50 + 32'(i);
      cyc();
    end
    wr_valid[2] = 1'b0;
    repeat (4) cyc();
    n_total++; if (count[2] !== 5'd5) $display("FAIL simul_pre_count: got %0d want 5", count[2]); else n_pass++;
    n_total++; if (rd_data[2] !== 32'h50) $display("FAIL simul_pre_head: got %h want 50", rd_data[2]); else n_pass++;
    wr_valid[2] = 1'b1; wr_data[2] = 32'h55; rd_ready[2] = 1'b1;
    cyc();
    wr_valid[2] = 1'b0; rd_ready[2] = 1'b0;
    n_total++; if (count[2] !== 5'd5) $display("FAIL simul_count: got %0d want 5", count[2]); else n_pass++;
    n_total++; if (rd_data[2] !== 32'h51) $display("FAIL simul_head: got %h want 51", rd_data[2]); else n_pass++;
    wr_valid[2] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wr_data[2] = 32'h56 + 32'(i);
      cyc();
    end
    n_total++; if (count[2] !== 5'd9) $display("FAIL flush_pre_count: got %0d want 9", count[2]); else n_pass++;
    flush[2] = 1'b1; wr_data[2] = 32'hEE;
    cyc();
    flush[2] = 1'b0; wr_valid[2] = 1'b0;
    n_total++; if (count[2] !== 5'd0) $display("FAIL flush_count: got %0d want 0", count[2]); else n_pass++;
    n_total++; if (rd_valid[2] !== 1'b0) $display("FAIL flush_rd_valid: got %b want 0", rd_valid[2]); else n_pass++;
    n_total++; if (almost_empty[2] !== 1'b1) $display("FAIL flush_ae: got %b want 1", almost_empty[2]); else n_pass++;
    repeat (5) cyc();
    n_total++; if (rd_valid[2] !== 1'b0) $display("FAIL flush_settled_valid: got %b want 0", rd_valid[2]); else n_pass++;
    n_total++; if (count[2] !== 5'd0) $display("FAIL flush_settled_count: got %0d want 0", count[2]); else n_pass++;
    wr_valid[2] = 1'b1; wr_data[2] = 32'h77;
    cyc();
    wr_valid[2] = 1'b0;
    w = 0;
    while (rd_valid[2] !== 1'b1 && w < 10) begin
      cyc();
      w++;
    end
    n_total++; if (rd_valid[2] !== 1'b1) $display("FAIL flush_after_valid: got %b want 1", rd_valid[2]); else n_pass++;
    n_total++; if (rd_data[2] !== 32'h77) $display("FAIL flush_after_data: got %h want 77", rd_data[2]); else n_pass++;
    rd_ready[2] = 1'b1;
    cyc();
    rd_ready[2] = 1'b0;
  endtask

  task automatic test_stream_stall();
    int nw, nr, max_cnt;
    nw = 0; nr = 0; max_cnt = 0;
    for (int c = 0; c < 2000 && nr < 100; c++) begin
      wr_valid[3] = (nw < 100);
      wr_data[3]  = 32'(nw);
      rd_ready[3] = 1'($urandom_range(0, 1));
      if (int'(count[3]) > max_cnt) max_cnt = int'(count[3]);
      if (wr_valid[3] && wr_ready[3]) nw++;
      if (rd_valid[3] && rd_ready[3]) begin
        n_total++; if (rd_data[3] !== 32'(nr)) $display("FAIL stream_data: got %0d want %0d", rd_data[3], nr); else n_pass++;
        nr++;
      end
      cyc();
    end
    wr_valid[3] = 1'b0; rd_ready[3] = 1'b0;
    n_total++; if (nr !== 100) $display("FAIL stream_words: got %0d want 100", nr); else n_pass++;
    n_total++; if (max_cnt > 16) $display("FAIL stream_max_count: got %0d want <=16", max_cnt); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int nw, nr, first_c, last_c;
    nw = 0; nr = 0; first_c = -1; last_c = -1;
    rd_ready[1] = 1'b1;
    for (int c = 0; c < 200 && nr < 40; c++) begin
      wr_valid[1] = (nw < 40);
      wr_data[1]  = 32'(nw);
      if (wr_valid[1] && wr_ready[1]) nw++;
      if (rd_valid[1] && rd_ready[1]) begin
        n_total++; if (rd_data[1] !== 32'(nr)) $display("FAIL wrap_data: got %0d want %0d", rd_data[1], nr); else n_pass++;
        if (first_c < 0) first_c = c;
        last_c = c;
        nr++;
      end
      cyc();
    end
    wr_valid[1] = 1'b0; rd_ready[1] = 1'b0;
    n_total++; if (nr !== 40) $display("FAIL wrap_words: got %0d want 40", nr); else n_pass++;
    n_total++; if (last_c - first_c !== 39) $display("FAIL wrap_throughput: got span %0d want 39", last_c - first_c); else n_pass++;
  endtask

  task automatic test_async_reset();
    int w;
    wr_valid[2] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wr_data[2] = 32'h60 + 32'(i);
      cyc();
    end
    wr_valid[2] = 1'b0;
    repeat (4) cyc();
    n_total++; if (rd_valid[2] !== 1'b1) $display("FAIL arst_pre_valid: got %b want 1", rd_valid[2]); else n_pass++;
    #3;
    rst_n = 1'b0;
    #1;
    n_total++; if (rd_valid[2] !== 1'b0) $display("FAIL arst_rd_valid: got %b want 0", rd_valid[2]); else n_pass++;
    n_total++; if (count[2] !== 5'd0) $display("FAIL arst_count: got %0d want 0", count[2]); else n_pass++;
    n_total++; if (wr_ready[2] !== 1'b1) $display("FAIL arst_wr_ready: got %b want 1", wr_ready[2]); else n_pass++;
    cyc();
    wr_valid[2] = 1'b1; wr_data[2] = 32'hBAD;
    cyc();
    wr_valid[2] = 1'b0;
    rst_n = 1'b1;
    cyc();
    n_total++; if (count[2] !== 5'd0) $display("FAIL arst_write_ignored: got %0d want 0", count[2]); else n_pass++;
    wr_valid[2] = 1'b1; wr_data[2] = 32'h3C;
    cyc();
    wr_valid[2] = 1'b0;
    w = 0;
    while (rd_valid[2] !== 1'b1 && w < 10) begin
      cyc();
      w++;
    end
    n_total++; if (rd_valid[2] !== 1'b1) $display("FAIL arst_after_valid: got %b want 1", rd_valid[2]); else n_pass++;
    n_total++; if (rd_data[2] !== 32'h3C) $display("FAIL arst_after_data: got %h want 3c", rd_data[2]); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_latency();
    test_show_ahead();
    test_fill();
    test_simul_and_flush();
    test_stream_stall();
    test_back_to_back();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
